// File: rtl/rv32_mini_core.sv
// Single-cycle RV32 integer core covering the R-type / I-type ALU subset.
// Fixed instruction ROM, 32x32 register file, decoder, sign extender and 8-op ALU.

// 12-bit immediate sign extension.
module rv32_mini_core_sext (
  input  logic [11:0] imm,
  output logic [31:0] value
);
  assign value = {{20{imm[11]}}, imm};
endmodule

// 8-op integer ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT.
module rv32_mini_core_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] y
);
  // Select the result for the requested operation.
  always_comb begin
    case (op)
      3'd0:    y = a + b;
      3'd1:    y = a - b;
      3'd2:    y = a & b;
      3'd3:    y = a | b;
      3'd4:    y = a ^ b;
      3'd5:    y = a << b[4:0];
      3'd6:    y = a >> b[4:0];
      default: y = {31'b0, $signed(a) < $signed(b)};
    endcase
  end
endmodule

module rv32_mini_core #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out_check,
  output logic [31:0] instruction_check,
  output logic [2:0]  alu_op_check,
  output logic [31:0] register_data_out1_check,
  output logic [31:0] register_data_out2_check,
  output logic [31:0] register_data_in_check,
  output logic [31:0] alu_result_check
);
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  logic [31:0] pc;
  logic        run;
  logic [31:0] regs [32];
  logic [31:0] instr;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        is_op;
  logic        is_imm;

  alu_op_t     alu_op;
  logic        wr_en;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm_ext;
  logic [31:0] alu_b;
  logic [31:0] alu_y;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign is_op  = (opcode == OPC_OP);
  assign is_imm = (opcode == OPC_OP_IMM);

  // Instruction ROM: only word 0 holds code; out-of-range indices read zero.
  always_comb begin
    instr = '0;
    if ({2'b00, pc[31:2]} < IMEM_LIMIT) begin
      case (pc[31:2])
        30'd0:   instr = 32'h005303b3;
        default: instr = '0;
      endcase
    end
  end

  // Decode: unsupported encodings leave alu_op at ADD with the write disabled.
  always_comb begin
    alu_op = ALU_ADD;
    wr_en  = 1'b0;
    if (is_op || is_imm) begin
      case (funct3)
        3'b000: begin
          if (is_imm || funct7 == 7'b0000000) begin
            alu_op = ALU_ADD;
            wr_en  = 1'b1;
          end else if (funct7 == 7'b0100000) begin
            alu_op = ALU_SUB;
            wr_en  = 1'b1;
          end
        end
        3'b111: begin alu_op = ALU_AND; wr_en = 1'b1; end
        3'b110: begin alu_op = ALU_OR;  wr_en = 1'b1; end
        3'b100: begin alu_op = ALU_XOR; wr_en = 1'b1; end
        3'b010: begin alu_op = ALU_SLT; wr_en = 1'b1; end
        3'b001: begin
          if (funct7 == 7'b0000000) begin alu_op = ALU_SLL; wr_en = 1'b1; end
        end
        3'b101: begin
          if (funct7 == 7'b0000000) begin alu_op = ALU_SRL; wr_en = 1'b1; end
        end
        default: ;
      endcase
    end
  end

  assign rs1_data = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign alu_b    = is_imm ? imm_ext : rs2_data;

  rv32_mini_core_sext u_sext (
    .imm   (instr[31:20]),
    .value (imm_ext)
  );

  rv32_mini_core_alu u_alu (
    .a  (rs1_data),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  // PC, run flag and register file; the first edge after reset only arms run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      run     <= 1'b0;
      regs[0] <= '0;
      for (int unsigned i = 1; i < 32; i++) begin
        regs[i] <= 32'd3000 + i;
      end
    end else if (!run) begin
      run <= 1'b1;
    end else begin
      pc <= pc + 32'd4;
      if (wr_en && rd != 5'd0) begin
        regs[rd] <= alu_y;
      end
    end
  end

  assign pc_out_check             = pc;
  assign instruction_check        = instr;
  assign alu_op_check             = alu_op;
  assign register_data_out1_check = rs1_data;
  assign register_data_out2_check = rs2_data;
  assign register_data_in_check   = alu_y;
  assign alu_result_check         = alu_y;
endmodule

// File: tb/tb_rv32_mini_core.sv
// Directed bench for rv32_mini_core: fetch/execute of the ROM program, reset
// behaviour, PC stepping past the ROM, PC wrap at 2^32, ALU and sign extender.
module tb_rv32_mini_core;
  logic        clk;
  logic        reset;

  logic [31:0] pc, instr, out1, out2, din, res;
  logic [2:0]  aop;
  logic [31:0] pc_w, instr_w, out1_w, out2_w, din_w, res_w;
  logic [2:0]  aop_w;

  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_sel;
  logic [11:0] imm;
  logic [31:0] imm_ext;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  rv32_mini_core dut (
    .clk                      (clk),
    .reset                    (reset),
    .pc_out_check             (pc),
    .instruction_check        (instr),
    .alu_op_check             (aop),
    .register_data_out1_check (out1),
    .register_data_out2_check (out2),
    .register_data_in_check   (din),
    .alu_result_check         (res)
  );

  // Second core starting just below 2^32 so the PC wraps onto the program.
  rv32_mini_core #(
    .IMEM_WORDS (256),
    .RESET_PC   (32'hFFFF_FFF8)
  ) dut_w (
    .clk                      (clk),
    .reset                    (reset),
    .pc_out_check             (pc_w),
    .instruction_check        (instr_w),
    .alu_op_check             (aop_w),
    .register_data_out1_check (out1_w),
    .register_data_out2_check (out2_w),
    .register_data_in_check   (din_w),
    .alu_result_check         (res_w)
  );

  rv32_mini_core_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_sel),
    .y  (alu_y)
  );

  rv32_mini_core_sext u_sext (
    .imm   (imm),
    .value (imm_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] alu_av  [10] = '{32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4,
                                 32'hFFFF_FFFF, 32'd1};
  logic [31:0] alu_bv  [10] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
                                 32'd0, 32'hFFFF_FFFF};
  logic [2:0]  alu_ov  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
  logic [31:0] alu_ev  [10] = '{32'd6, 32'd2, 32'd0, 32'd6, 32'd6, 32'd16, 32'd1, 32'd0,
                                 32'd1, 32'd0};

  initial begin
    reset   = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    imm     = '0;

    // During reset
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_pc_w", pc_w, 32'hFFFF_FFF8);
    check("rst_instr_w", instr_w, 32'h0);
    check("rst_x7", dut.regs[7], 32'd3007);
    check("rst_x0", dut.regs[0], 32'd0);

    // Released, before any edge
    reset = 1'b1;
    #1;
    check("t1_pc", pc, 32'h0);
    check("t1_instr", instr, 32'h005303b3);
    check("t1_aluop", {29'b0, aop}, 32'd0);
    check("t1_out1", out1, 32'd3006);
    check("t1_out2", out2, 32'd3005);
    check("t1_result", res, 32'd6011);
    check("t1_din", din, 32'd6011);

    // First edge arms run only
    step();
    check("t2a_pc", pc, 32'h0);
    check("t2a_x7", dut.regs[7], 32'd3007);
    check("t2a_pc_w", pc_w, 32'hFFFF_FFF8);

    // Second edge commits the add
    step();
    check("t2b_pc", pc, 32'h4);
    check("t2b_instr", instr, 32'h0);
    check("t2b_x7", dut.regs[7], 32'd6011);
    check("t2b_result", res, 32'd0);
    check("t2b_aluop", {29'b0, aop}, 32'd0);
    check("t2b_pc_w", pc_w, 32'hFFFF_FFFC);
    check("t2b_x7_w", dut_w.regs[7], 32'd3007);

    // Wrapped core reaches the program at PC 0
    step();
    check("wrap_pc_w", pc_w, 32'h0);
    check("wrap_instr_w", instr_w, 32'h005303b3);
    check("wrap_out1_w", out1_w, 32'd3006);
    check("wrap_res_w", res_w, 32'd6011);
    step();
    check("wrap_pc_w2", pc_w, 32'h4);
    check("wrap_x7_w", dut_w.regs[7], 32'd6011);

    // Asynchronous reset between edges
    #3;
    reset = 1'b0;
    #1;
    check("t4_pc", pc, 32'h0);
    check("t4_x7", dut.regs[7], 32'd3007);
    check("t4_pc_w", pc_w, 32'hFFFF_FFF8);
    #2;
    reset = 1'b1;

    // Step past the ROM: arm edge, commit edge at PC 0, then empty words
    step();
    for (int i = 0; i < 255; i++) step();
    check("t5_pc_last", pc, 32'd1020);
    check("t5_instr_last", instr, 32'h0);
    step();
    check("t5_pc_beyond", pc, 32'd1024);
    check("t5_instr_beyond", instr, 32'h0);
    check("t5_out1_beyond", out1, 32'd0);
    check("t5_res_beyond", res, 32'd0);
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp_reg;
      exp_reg = (i == 0) ? 32'd0 : (i == 7) ? 32'd6011 : 32'd3000 + 32'(i);
      check($sformatf("t5_x%0d", i), dut.regs[i], exp_reg);
    end

    // ALU vectors
    for (int i = 0; i < 10; i++) begin
      alu_a   = alu_av[i];
      alu_b   = alu_bv[i];
      alu_sel = alu_ov[i];
      #1;
      check($sformatf("alu_%0d_op%0d", i, alu_sel), alu_y, alu_ev[i]);
    end
    alu_a = 32'd1; alu_b = 32'd33; alu_sel = 3'd5; #1;
    check("alu_sll_b40", alu_y, 32'd2);
    alu_a = 32'h8000_0000; alu_b = 32'd31; alu_sel = 3'd6; #1;
    check("alu_srl_logical", alu_y, 32'd1);
    alu_a = 32'd0; alu_b = 32'd1; alu_sel = 3'd1; #1;
    check("alu_sub_wrap", alu_y, 32'hFFFF_FFFF);
    alu_a = 32'hFFFF_FFFF; alu_b = 32'd1; alu_sel = 3'd0; #1;
    check("alu_add_wrap", alu_y, 32'h0);

    // Sign extension
    imm = 12'b101010101010; #1;
    check("sext_neg", imm_ext, 32'hFFFF_FAAA);
    imm = 12'b010101010101; #1;
    check("sext_pos", imm_ext, 32'h0000_0555);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
